// File: rtl/uart_rx_fifo_if.sv
// Receiver capture handshake plus host read port of uart_rx_fifo;
// master = receiver/host side, slave = FIFO side.
interface uart_rx_fifo_if;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_framing_err;
    logic       rx_overrun;
    logic       host_ready;
    logic       clear_framing_err;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       rd_ready;

    modport master (
        output rx_data, rx_data_valid, rx_framing_err, rx_overrun, rd_ready,
        input  host_ready, clear_framing_err, rd_data, rd_err, rd_valid
    );

    modport slave (
        input  rx_data, rx_data_valid, rx_framing_err, rx_overrun, rd_ready,
        output host_ready, clear_framing_err, rd_data, rd_err, rd_valid
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// FWFT receive byte FIFO behind the UART receiver; 1-cycle write-to-read, host_ready low only when full.
// UART_RX_FIFO_ERR_TAG_EN stores a framing-error tag per byte and pulses clear_framing_err on capture.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_rx_fifo_if.slave          rx,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   overrun_sticky,
    output logic [7:0]             overrun_events,
    input  logic                   status_clear
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;
    logic          wr_en;
    logic          rd_en;
    logic          overrun_prev;
    logic          overrun_rise;

    assign rx.host_ready = (count != CW'(DEPTH));
    assign rx.rd_valid   = (count != '0);
    assign wr_en         = rx.rx_data_valid && rx.host_ready;
    assign rd_en         = rx.rd_valid && rx.rd_ready;

    // Gate the head with rd_valid so stale storage never shows after reset or drain.
    assign head          = rx.rd_valid ? mem[rd_ptr] : '0;
    assign rx.rd_data    = head[7:0];

`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign wr_entry             = {rx.rx_framing_err, rx.rx_data};
    assign rx.rd_err            = head[8];
    assign rx.clear_framing_err = wr_en;
`else
    logic unused_framing;
    assign unused_framing       = rx.rx_framing_err;
    assign wr_entry             = rx.rx_data;
    assign rx.rd_err            = 1'b0;
    assign rx.clear_framing_err = 1'b0;
`endif

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count       <= count_nxt;
            almost_full <= (count_nxt >= CW'(AFULL_LEVEL));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_entry;
    end

    assign overrun_rise = rx.rx_overrun && !overrun_prev;

    // Set/increment takes priority over a coincident status_clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_prev   <= 1'b0;
            overrun_sticky <= 1'b0;
            overrun_events <= 8'd0;
        end else begin
            overrun_prev <= rx.rx_overrun;
            if (rx.rx_overrun)     overrun_sticky <= 1'b1;
            else if (status_clear) overrun_sticky <= 1'b0;
            if (overrun_rise) begin
                if (status_clear)                 overrun_events <= 8'd1;
                else if (overrun_events != 8'hFF) overrun_events <= overrun_events + 8'd1;
            end else if (status_clear) begin
                overrun_events <= 8'd0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] count;
    logic       almost_full;
    logic       overrun_sticky;
    logic [7:0] overrun_events;
    logic       status_clear;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx             (bus),
        .count          (count),
        .almost_full    (almost_full),
        .overrun_sticky (overrun_sticky),
        .overrun_events (overrun_events),
        .status_clear   (status_clear)
    );

    always #5 clk = ~clk;

    logic [8:0] q[$];
    int         m_sticky;
    int         m_events;
    bit         m_prev;
    int         vectors;
    int         miscompares;

    wire [25:0] dut_vec = {bus.rd_valid, bus.rd_data, bus.rd_err, count, bus.host_ready,
                           almost_full, overrun_sticky, overrun_events};

    function automatic logic [25:0] exp_vec();
        logic [7:0] d;
        logic       e;
        d = 8'h00;
        e = 1'b0;
        if (q.size() > 0) begin
            d = q[0][7:0];
            e = ERR_EN ? q[0][8] : 1'b0;
        end
        return {q.size() != 0, d, e, 5'(q.size()), q.size() != DEPTH,
                q.size() >= AFULL, m_sticky != 0, 8'(m_events)};
    endfunction

    function automatic logic exp_clr();
        return ERR_EN && bus.rx_data_valid && (q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        q.delete();
        m_sticky = 0;
        m_events = 0;
        m_prev   = 1'b0;
    endtask

    task automatic idle();
        bus.rx_data        = 8'h00;
        bus.rx_data_valid  = 1'b0;
        bus.rx_framing_err = 1'b0;
        bus.rx_overrun     = 1'b0;
        bus.rd_ready       = 1'b0;
        status_clear       = 1'b0;
    endtask

    // Advance one clock edge, applying the specified write/pop/overrun rules to the model.
    task automatic tick();
        bit         w;
        bit         p;
        bit         ov;
        bit         clr;
        logic [8:0] ent;
        w   = bus.rx_data_valid && (q.size() < DEPTH);
        p   = bus.rd_ready && (q.size() > 0);
        ov  = bus.rx_overrun;
        clr = status_clear;
        ent = {bus.rx_framing_err, bus.rx_data};
        @(posedge clk);
        if (p) void'(q.pop_front());
        if (w) q.push_back(ent);
        if (ov)       m_sticky = 1;
        else if (clr) m_sticky = 0;
        if (ov && !m_prev) m_events = clr ? 1 : (m_events < 255 ? m_events + 1 : 255);
        else if (clr)      m_events = 0;
        m_prev = ov;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if (dut_vec !== exp_vec() || bus.clear_framing_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got %h clr %b want %h clr 0", dut_vec, bus.clear_framing_err, exp_vec());
        end
    endtask

    task automatic test_single();
        bus.rx_data = 8'hA5;
        bus.rx_data_valid = 1'b1;
        vectors++;
        if (bus.clear_framing_err !== exp_clr()) begin
            miscompares++;
            $display("FAIL single_clr: got %b want %b", bus.clear_framing_err, exp_clr());
        end
        tick();
        bus.rx_data_valid = 1'b0;
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL single_write: got %h want %h", dut_vec, exp_vec());
        end
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL single_pop: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            bus.rx_data = 8'(i);
            bus.rx_data_valid = 1'b1;
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL fill[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        bus.rx_data = 8'h10;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.clear_framing_err !== exp_clr()) begin
                miscompares++;
                $display("FAIL full_clr[%0d]: got %b want %b", i, bus.clear_framing_err, exp_clr());
            end
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_hold[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL full_pop: got %h want %h", dut_vec, exp_vec());
        end
        tick();
        bus.rx_data_valid = 1'b0;
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL full_refill: got %h want %h", dut_vec, exp_vec());
        end
        bus.rd_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL full_drain[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.rx_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rx_data = 8'($urandom);
            tick();
        end
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 45; i++) begin
            bus.rx_data = 8'($urandom);
            tick();
            vectors++;
            if (dut_vec !== exp_vec() || count !== 5'd3) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        bus.rx_data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL b2b_drain[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_overrun();
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rx_overrun = 1'b1;
            tick();
            bus.rx_overrun = 1'b0;
            repeat (2) begin
                vectors++;
                if (dut_vec !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL ovr_pulse[%0d]: got %h want %h", i, dut_vec, exp_vec());
                end
                tick();
            end
        end
        vectors++;
        if (overrun_events !== 8'd3 || overrun_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_three: got %0d/%b want 3/1", overrun_events, overrun_sticky);
        end
        bus.rx_overrun = 1'b1;
        status_clear = 1'b1;
        tick();
        bus.rx_overrun = 1'b0;
        status_clear = 1'b0;
        vectors++;
        if (dut_vec !== exp_vec() || overrun_events !== 8'd1) begin
            miscompares++;
            $display("FAIL ovr_clear_race: got %h want %h", dut_vec, exp_vec());
        end
        for (int i = 0; i < 260; i++) begin
            bus.rx_overrun = 1'b1;
            tick();
            bus.rx_overrun = 1'b0;
            tick();
        end
        vectors++;
        if (dut_vec !== exp_vec() || overrun_events !== 8'hFF) begin
            miscompares++;
            $display("FAIL ovr_saturate: got %h want %h", dut_vec, exp_vec());
        end
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL ovr_clear: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_framing();
        logic [7:0] bytes [2];
        bytes[0] = 8'h55;
        bytes[1] = 8'h66;
        bus.rx_data_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.rx_data = bytes[i];
            bus.rx_framing_err = (i == 0);
            vectors++;
            if (bus.clear_framing_err !== exp_clr()) begin
                miscompares++;
                $display("FAIL frame_clr[%0d]: got %b want %b", i, bus.clear_framing_err, exp_clr());
            end
            tick();
        end
        bus.rx_data_valid = 1'b0;
        bus.rx_framing_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL frame_read[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
            bus.rd_ready = 1'b1;
            tick();
        end
        bus.rd_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.rx_data        = 8'($urandom);
            bus.rx_data_valid  = ($urandom_range(0, 3) != 0);
            bus.rx_framing_err = ($urandom_range(0, 3) == 0);
            bus.rx_overrun     = ($urandom_range(0, 7) == 0);
            bus.rd_ready       = ($urandom_range(0, 2) == 0);
            status_clear       = ($urandom_range(0, 15) == 0);
            vectors++;
            if (bus.clear_framing_err !== exp_clr()) begin
                miscompares++;
                $display("FAIL rand_clr[%0d]: got %b want %b", i, bus.clear_framing_err, exp_clr());
            end
            tick();
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL rand[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        model_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.rx_data_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.rx_data = 8'($urandom_range(1, 255));
            tick();
        end
        bus.rx_data_valid = 1'b0;
        vectors++;
        if (count !== 5'd7) begin
            miscompares++;
            $display("FAIL arst_pre: count %0d want 7", count);
        end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({count, bus.rd_valid, bus.host_ready, bus.rd_data} !== {5'd0, 1'b0, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL arst: count %0d rd_valid %b host_ready %b rd_data %h want 0 0 1 00",
                     count, bus.rd_valid, bus.host_ready, bus.rd_data);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL arst_release: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It drives the receiver's `host_ready` and captures each completed byte into a first-word-fall-through FIFO. It tags each byte with its framing-error status and keeps sticky and counted overrun status for the host. It decouples host read latency from line timing, so the receiver's single-byte holding buffer rarely reaches overrun.

## Interface
- `DEPTH`, 16, number of byte entries; power of two, ≥ 2.
- `AFULL_LEVEL`, 12, `almost_full` asserts when `count` ≥ this value; must satisfy 1 ≤ `AFULL_LEVEL` ≤ `DEPTH`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx_data` in 8: byte from the receiver.
- `rx_data_valid` in 1: receiver holding buffer is full.
- `rx_framing_err` in 1: receiver's sticky framing-error flag.
- `rx_overrun` in 1: receiver overrun level.
- `host_ready` out 1: FIFO can accept a byte this cycle.
- `clear_framing_err` out 1: clears the receiver's framing flag.
- `rd_data` out 8: head byte.
- `rd_err` out 1: framing-error tag of the head byte.
- `rd_valid` out 1: head entry present.
- `rd_ready` in 1: host pops the head entry.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `almost_full` out 1: occupancy ≥ `AFULL_LEVEL`.
- `overrun_sticky` out 1: an overrun has occurred since the last clear.
- `overrun_events` out 8: count of overrun episodes, saturating.
- `status_clear` in 1: clears `overrun_sticky` and `overrun_events`.

## Operation
- **Write (capture)**
  - A byte is captured on every rising edge where `rx_data_valid && host_ready`.
  - `host_ready = (count != DEPTH)`. It is combinational from registered `count` only and has no same-cycle dependence on `rd_ready`.
  - The receiver guarantees that `rx_data_valid` drops or `rx_data` changes after each accepted cycle. Holding `host_ready` high therefore never double-captures.
- **Read (pop)**
  - `rd_valid = (count != 0)`.
  - `rd_data` and `rd_err` always show the entry at the read pointer.
  - A pop occurs on an edge where `rd_valid && rd_ready`. `rd_ready` while empty is ignored.
- **Pointers**
  - Write and read pointers are $clog2(DEPTH) bits wide and wrap modulo `DEPTH`.
  - `count` is tracked separately, range 0..`DEPTH`.
- **Simultaneous write and pop**: both pointers advance and `count` is unchanged.
- **Full**
  - `host_ready` is low. The receiver keeps its byte, and a further incoming byte produces `rx_overrun` in the receiver.
  - A pop while full frees the slot. `host_ready` rises the next cycle.
- **Overrun tracking**
  - `overrun_sticky` is set on any cycle where `rx_overrun` is high.
  - `overrun_events` increments on each rising edge of `rx_overrun`, using a registered previous value. It saturates at 255.
  - `status_clear` clears both. If set/increment and clear occur in the same cycle, set/increment wins and the result is sticky = 1, events = 1.
- **Framing**: handling is per Configuration.

## Timing
- **Reset values** (asynchronous, active-low): pointers, `count` = 0; `rd_valid` = 0; `host_ready` = 1; `rd_data` = 0x00; `rd_err` = 0; `almost_full` = 0; `overrun_sticky` = 0; `overrun_events` = 0; `clear_framing_err` = 0; previous-`rx_overrun` register = 0.
- **Reset mid-operation**: all contents are discarded. The storage array need not be reset, but `rd_data` must read 0x00 while `count` = 0.
- **Latency**: a byte captured at edge N gives `rd_valid` = 1 with that byte on `rd_data` in the cycle after N (1-cycle write-to-read). A pop at edge N shows the next entry in the cycle after N.
- **Registered outputs**: `count`, `almost_full`, `overrun_sticky` and `overrun_events` are registered. `host_ready`, `rd_valid`, `rd_data` and `rd_err` are decoded from registered state.
- **`clear_framing_err`**: combinational, equal to `rx_data_valid && host_ready` (asserted in the capture cycle) when the feature is enabled; otherwise 0.

## Configuration
- Macro: `UART_RX_FIFO_ERR_TAG_EN`.
- **Defined**
  - Each entry stores 9 bits: `{rx_framing_err, rx_data}` sampled at capture.
  - `clear_framing_err` pulses in every capture cycle. Because the receiver's set has priority over clear, errors on the following byte are never lost.
  - `rd_err` reflects the head entry's tag.
- **Undefined**
  - Entries are 8 bits. `rd_err` is tied to 0 and `clear_framing_err` is tied to 0.
  - The framing flag remains sticky inside the receiver for software to manage.

## Test plan
- After reset, write 0xA5 with `rd_ready` = 0 → next cycle `rd_valid` = 1, `rd_data` = 0xA5, `count` = 1, `host_ready` = 1.
- Write 16 bytes 0x00..0x0F with no reads (`DEPTH` = 16) → `count` = 16, `host_ready` = 0, `almost_full` = 1 from `count` = 12. Hold `rx_data_valid` 5 cycles → no capture. Pop once → `host_ready` = 1 the next cycle, then 0x10 is captured.
- Continuous write and pop in the same cycles across ≥ 40 bytes (pointer wrap) → `count` stays constant, output order is exact, no loss.
- Pulse `rx_overrun` three separate times, then `status_clear` coincident with a fourth rising edge → `overrun_events` = 3, then 1; `overrun_sticky` = 1 throughout.
- With `UART_RX_FIFO_ERR_TAG_EN`: capture 0x55 while `rx_framing_err` = 1, then 0x66 with it 0 → `clear_framing_err` pulses in both capture cycles; reads give `rd_err` = 1 then 0. Without the macro, `rd_err` = 0 for both.
- Assert `rst_n` low with `count` = 7 → asynchronously `count` = 0, `rd_valid` = 0, `host_ready` = 1, `rd_data` = 0x00.
